cmem_line_fill: RTL and testbench

//  Responder end of the L2 refill bus: serves block reads issued by the cache
//  (b_addr_c/b_rd_c in, b_rdata_c/b_dv_c out). Splits each line request into
//  64-bit beat reads on a pipelined memory port, assembles the beats into one

---
 rtl/cmem_line_fill.sv | 127 ++++++++++++
 tb/tb_cmem_line_fill.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_line_fill.sv
// rtl/cmem_line_fill.sv - L2 refill responder: splits a line read into pipelined 64-bit beat reads
// and returns the assembled line with a one-cycle valid strobe.
module cmem_line_fill #(
  parameter int BLK_LEN = 58,
  parameter int LINE    = 512,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLK_LEN-1:0] b_addr_c,
  input  logic               b_rd_c,
  output logic [LINE-1:0]    b_rdata_c,
  output logic               b_dv_c,
  output logic [63:0]        m_addr,
  output logic               m_req,
  input  logic               m_gnt,
  input  logic [63:0]        m_rdata,
  input  logic               m_rvalid,
  output logic               err
);

  localparam int BEATS = LINE / 64;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = BW + 1;
  localparam int AW    = BLK_LEN + BW + 3;
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_VALID = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  logic [2:0]         r_state;
  logic [BLK_LEN-1:0] r_blk;
  logic [CW-1:0]      r_iss;
  logic [CW-1:0]      r_ret;
  logic [LINE-1:0]    r_line;
  logic [LINE-1:0]    r_rdata;
  logic               r_err;

  logic [2:0]         w_state_nxt;
  logic [CW-1:0]      w_out;
  logic [CW-1:0]      w_iss_nxt;
  logic [CW-1:0]      w_ret_nxt;
  logic               w_gnt_ok;
  logic               w_rv_ok;
  logic [LINE-1:0]    w_line_nxt;
  logic [AW-1:0]      w_addr_full;

  always_comb begin
    w_out     = r_iss - r_ret;
    m_req     = (r_state == S_FILL) && (r_iss < BEATS_C) && (w_out < MAXO_C);
    w_gnt_ok  = m_req && m_gnt;
    // A response is only legal while at least one beat is in flight.
    w_rv_ok   = m_rvalid && (r_iss != r_ret);
    w_iss_nxt = w_gnt_ok ? r_iss + 1'b1 : r_iss;
    w_ret_nxt = w_rv_ok ? r_ret + 1'b1 : r_ret;
    w_line_nxt = r_line;
    if (w_rv_ok && (r_state == S_FILL)) begin
      w_line_nxt[{r_ret[BW-1:0], 6'd0} +: 64] = m_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (b_rd_c) w_state_nxt = S_FILL;
      S_FILL: begin
        if (!b_rd_c) begin
          w_state_nxt = S_ABORT;
        end else if (w_ret_nxt == BEATS_C) begin
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: w_state_nxt = S_DONE;
      S_DONE:  if (!b_rd_c) w_state_nxt = S_IDLE;
      S_ABORT: if (w_ret_nxt == r_iss) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_blk   <= '0;
      r_iss   <= '0;
      r_ret   <= '0;
      r_line  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_iss   <= w_iss_nxt;
      r_ret   <= w_ret_nxt;
      r_line  <= w_line_nxt;
      if (m_rvalid && !w_rv_ok) begin
        r_err <= 1'b1;
      end
      if ((r_state == S_IDLE) && b_rd_c) begin
        r_blk <= b_addr_c;
        r_iss <= '0;
        r_ret <= '0;
      end
      // Output copy keeps the previous line stable while the next one assembles.
      if ((r_state == S_FILL) && (w_state_nxt == S_VALID)) begin
        r_rdata <= w_line_nxt;
      end
    end
  end

  assign w_addr_full = {r_blk, r_iss[BW-1:0], 3'b000};

  generate
    if (AW >= 64) begin : g_addr_trunc
      assign m_addr = w_addr_full[63:0];
    end else begin : g_addr_pad
      assign m_addr = {{(64 - AW){1'b0}}, w_addr_full};
    end
  endgenerate

  assign b_dv_c    = (r_state == S_VALID);
  assign b_rdata_c = r_rdata;
  assign err       = r_err;

endmodule

// File: tb/tb_cmem_line_fill.sv
// tb/tb_cmem_line_fill.sv - directed bench for cmem_line_fill with memory model and line scoreboard.
module tb_cmem_line_fill;

  localparam int BLK_LEN = 58;
  localparam int LINE    = 512;
  localparam int MAX_OUT = 2;
  localparam int BEATS   = LINE / 64;

  typedef struct {
    int          due;
    logic [63:0] data;
    bit          real_r;
  } rsp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [BLK_LEN-1:0] b_addr_c;
  logic               b_rd_c;
  logic [LINE-1:0]    b_rdata_c;
  logic               b_dv_c;
  logic [63:0]        m_addr;
  logic               m_req;
  logic               m_gnt;
  logic [63:0]        m_rdata;
  logic               m_rvalid;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dv_cnt = 0;

  rsp_t            pend[$];
  logic [LINE-1:0] exp_q[$];

  int                 gnt_pct = 100;
  int                 lat = 2;
  int                 gnt_limit = 1000;
  bit                 chk_stable = 1'b1;
  int                 gcount = 0;
  int                 rcount = 0;
  int                 out_cnt = 0;
  int                 max_seen = 0;
  int                 c_issue = 0;
  logic [BLK_LEN-1:0] cur_blk = '0;

  cmem_line_fill #(
    .BLK_LEN(BLK_LEN),
    .LINE   (LINE),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .b_addr_c (b_addr_c),
    .b_rd_c   (b_rd_c),
    .b_rdata_c(b_rdata_c),
    .b_dv_c   (b_dv_c),
    .m_addr   (m_addr),
    .m_req    (m_req),
    .m_gnt    (m_gnt),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .err      (err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [LINE-1:0] obs, input logic [LINE-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Memory model: random grant, fixed latency, in-order responses.
  initial begin
    bit          g;
    bit          prev_wait;
    logic [63:0] prev_addr;
    logic [63:0] exp_a;
    rsp_t        r;
    prev_wait = 1'b0;
    prev_addr = '0;
    m_gnt = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        out_cnt = 0;
        prev_wait = 1'b0;
        m_gnt = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
      end else begin
        if (chk_stable && prev_wait) begin
          chk("req_held", m_req, 1);
          chk("addr_held", m_addr, prev_addr);
        end
        if (out_cnt > max_seen) max_seen = out_cnt;
        if (m_req) chk("max_out", out_cnt < MAX_OUT, 1);
        m_rvalid = 1'b0;
        m_rdata = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          m_rvalid = 1'b1;
          m_rdata = pend[0].data;
          if (pend[0].real_r) begin
            out_cnt--;
            rcount++;
          end
          void'(pend.pop_front());
        end
        g = (gcount < gnt_limit) && ($urandom_range(0, 99) < gnt_pct);
        m_gnt = g;
        if (m_req && g) begin
          exp_a = {cur_blk, 3'(gcount), 3'b000};
          chk("beat_addr", m_addr, exp_a);
          r.due = cyc + lat;
          r.data = m_addr;
          r.real_r = 1'b1;
          pend.push_back(r);
          gcount++;
          out_cnt++;
        end
        prev_wait = m_req && !g;
        prev_addr = m_addr;
      end
    end
  end

  // Line scoreboard: every b_dv_c pulse must match the oldest expected line.
  initial begin
    logic [LINE-1:0] e;
    forever begin
      @(negedge clk);
      if (b_dv_c === 1'b1) begin
        dv_cnt++;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_bad++;
          $error("FAIL unexpected_dv: observed pulse expected none");
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("line_data", b_rdata_c, e);
        end
      end
    end
  end

  task automatic issue(input logic [BLK_LEN-1:0] a, input bit push);
    logic [LINE-1:0] line;
    for (int i = 0; i < BEATS; i++) line[64*i +: 64] = {a, 3'(i), 3'b000};
    gcount = 0;
    rcount = 0;
    cur_blk = a;
    b_addr_c = a;
    b_rd_c = 1'b1;
    c_issue = cyc;
    if (push) exp_q.push_back(line);
  endtask

  task automatic wait_dv(input string tag, output int dv_cyc);
    int k;
    bit got;
    k = 0;
    got = 1'b0;
    while (!got && k < 600) begin
      @(negedge clk);
      k++;
      if (b_dv_c === 1'b1) got = 1'b1;
    end
    dv_cyc = cyc;
    chk(tag, got, 1);
    @(negedge clk);
    b_rd_c = 1'b0;
  endtask

  initial begin
    int d;
    int c0;
    int dv0;
    int k;
    rsp_t s;
    rst = 1'b1;
    b_rd_c = 1'b0;
    b_addr_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_dv", b_dv_c, 0);
    chk("rst_req", m_req, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", b_rdata_c, 0);
    rst = 1'b0;

    // basic fill, latency 2
    @(negedge clk);
    issue(58'h10, 1'b1);
    wait_dv("t1_dv", d);
    chk("t1_dv_count", dv_cnt, 1);

    // zero-wait memory latency
    lat = 1;
    @(negedge clk);
    issue(58'h3a5, 1'b1);
    c0 = c_issue;
    wait_dv("lat_dv", d);
    chk("lat_cycles", d - c0, BEATS + 2);

    // grant backpressure
    gnt_pct = 30;
    lat = 3;
    @(negedge clk);
    issue(58'h2b7c, 1'b1);
    wait_dv("t2_dv", d);

    // long latency, outstanding limit
    gnt_pct = 100;
    lat = 10;
    max_seen = 0;
    @(negedge clk);
    issue(58'h1234_5678_9abc, 1'b1);
    wait_dv("t3_dv", d);
    chk("t3_max_out", max_seen, MAX_OUT);

    // abort after three grants
    lat = 2;
    chk_stable = 1'b0;
    gnt_limit = 3;
    @(negedge clk);
    issue(58'h77, 1'b0);
    k = 0;
    while (gcount < 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t4_grants", gcount, 3);
    b_rd_c = 1'b0;
    dv0 = dv_cnt;
    repeat (15) @(negedge clk);
    chk("t4_drained", rcount, 3);
    chk("t4_no_dv", dv_cnt, dv0);
    chk("t4_err", err, 0);
    chk("t4_idle_req", m_req, 0);
    gnt_limit = 1000;
    chk_stable = 1'b1;
    @(negedge clk);
    issue(58'h20, 1'b1);
    wait_dv("t4_next_dv", d);

    // back-to-back requests
    dv0 = dv_cnt;
    @(negedge clk);
    issue(58'h10, 1'b1);
    wait_dv("t5_dv_a", d);
    @(negedge clk);
    issue(58'h11, 1'b1);
    wait_dv("t5_dv_b", d);
    chk("t5_two_dv", dv_cnt - dv0, 2);

    // reset mid-fill, then a stray response
    chk_stable = 1'b0;
    @(negedge clk);
    issue(58'h30, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    b_rd_c = 1'b0;
    dv0 = dv_cnt;
    repeat (3) @(negedge clk);
    chk("t6_dv", b_dv_c, 0);
    chk("t6_req", m_req, 0);
    chk("t6_addr", m_addr, 0);
    chk("t6_rdata", b_rdata_c, 0);
    chk("t6_err_clr", err, 0);
    rst = 1'b0;
    @(negedge clk);
    s.due = cyc + 1;
    s.data = 64'hdead_beef;
    s.real_r = 1'b0;
    pend.push_back(s);
    repeat (4) @(negedge clk);
    chk("t6_err_set", err, 1);
    chk("t6_no_dv", dv_cnt, dv0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
